plab3_proc_fetch_unit: RTL and testbench
========================================

PLAB3_PROC_FETCH_UNIT -- requirements
Module: plab3_proc_fetch_unit

Interface
REQ-001 SHALL take parameter p_max_inflight, default 2, meaning the maximum number of outstanding imem requests (legal range 1..8).
REQ-002 SHALL take parameter c_reset_vector, default 32'h1000, meaning the first fetch PC after reset.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; reset  in  1  synchronous active-high reset.
REQ-004 SHALL have port sec_domain  in  1  security domain of the current fetch stream.
REQ-005 SHALL have ports redirect_val  in  1  and redirect_pc  in  32, meaning a branch/jump/exception target.
REQ-006 SHALL have ports imemreq_val  out  1, imemreq_rdy  in  1, imemreq_addr  out  32 and imemreq_domain  out  1.
REQ-007 SHALL have ports imemresp_val  in  1, imemresp_rdy  out  1, imemresp_data  in  32 and imemresp_domain  in  1.
REQ-008 SHALL have ports inst_val  out  1, inst_rdy  in  1, inst  out  32 (instruction) and inst_pc  out  32 (its PC).
REQ-009 SHALL have port fault  out  1, a one-cycle pulse on a domain-mismatched response.

Function
REQ-010 SHALL hold fetch PC register pc; imemreq_addr = pc; imemreq_domain = sec_domain.
REQ-011 SHALL assert imemreq_val iff !reset && !redirect_val && inflight < p_max_inflight.
REQ-012 SHALL, on request fire (imemreq_val && imemreq_rdy), set pc <= pc + 4 and push {pc, sec_domain} into an in-order tag FIFO of depth p_max_inflight.
REQ-013 SHALL, on redirect_val, set pc <= redirect_pc; the first request from redirect_pc SHALL issue no earlier than the following cycle.
REQ-014 SHALL keep inflight = tag FIFO occupancy, a counter of width clog2(p_max_inflight)+1, incremented on request fire and decremented on response fire; simultaneous fire leaves it unchanged.
REQ-015 SHALL maintain drop_cnt; on redirect, drop_cnt <= inflight minus 1 if a response fires in that cycle; otherwise drop_cnt decrements on each response fire while it is nonzero.
REQ-016 SHALL drive imemresp_rdy = 1 when drop_cnt != 0 or redirect_val; otherwise imemresp_rdy = inst_rdy.
REQ-017 SHALL drive inst_val = imemresp_val && drop_cnt == 0 && !redirect_val && !mismatch, with inst = imemresp_data and inst_pc = FIFO head PC (zero-latency pass-through).
REQ-018 SHALL pop the tag FIFO on every response fire, whether the response is delivered or dropped.
REQ-019 SHALL, when inflight == p_max_inflight, hold imemreq_val low until a response fires; a response fire and a new request fire in the same cycle are both legal at full occupancy.
REQ-020 SHALL treat a response arriving while inflight == 0 as a protocol error; behaviour in that case is unspecified.

Reset
REQ-021 SHALL, while reset is high, set pc = c_reset_vector, inflight = 0, drop_cnt = 0, tag FIFO empty, and imemreq_val = inst_val = fault = 0.
REQ-022 SHALL, when reset is asserted mid-operation, discard all in-flight state; the memory system is reset in the same cycle.

Configuration
REQ-023 SHALL, with PLAB3_PROC_FETCH_DOMAIN_CHECK_EN defined, set mismatch = imemresp_val && drop_cnt == 0 && imemresp_domain != FIFO head domain; a mismatched response SHALL be consumed (imemresp_rdy = 1), not delivered, and pulse fault for one cycle.
REQ-024 SHALL, with PLAB3_PROC_FETCH_DOMAIN_CHECK_EN undefined, hold mismatch = 0, tie fault to 0 and ignore imemresp_domain.

Verification
REQ-025 SHALL cover: reset release, mem always ready with 1-cycle response -> addresses 0x1000, 0x1004, 0x1008 issued on consecutive cycles and delivered in order with matching inst_pc.
REQ-026 SHALL cover: p_max_inflight = 2, responses withheld -> exactly 2 requests (0x1000, 0x1004) issued, then imemreq_val = 0 until a response fires.
REQ-027 SHALL cover: 2 in flight, redirect to 0x2000 -> both old responses consumed with inst_val = 0, next delivered inst_pc = 0x2000.
REQ-028 SHALL cover: redirect in the same cycle as a response fire with inflight = 2 -> drop_cnt = 1, only one further response dropped.
REQ-029 SHALL cover, with the macro defined: request with sec_domain = 1, response with imemresp_domain = 0 -> no inst_val, one-cycle fault pulse, inflight decremented; with the macro undefined -> instruction delivered and fault = 0.
REQ-030 SHALL cover: reset asserted with 2 in flight -> next cycle imemreq_addr = 0x1000, inflight = 0, drop_cnt = 0.

Source files
------------

// File: rtl/plab3_proc_fetch_unit.sv
// Instruction fetch unit: issues sequential imem requests from a fetch PC,
// tracks outstanding requests in an in-order tag FIFO, squashes stale
// responses after a redirect and forwards live responses to decode with
// zero latency.
// Optional feature macro: PLAB3_PROC_FETCH_DOMAIN_CHECK_EN enables the
// security-domain check on responses (mismatch consumed, fault pulsed).
module plab3_proc_fetch_unit #(
  parameter int          p_max_inflight = 2,
  parameter logic [31:0] c_reset_vector = 32'h1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sec_domain,
  input  logic        redirect_val,
  input  logic [31:0] redirect_pc,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_addr,
  output logic        imemreq_domain,
  input  logic        imemresp_val,
  output logic        imemresp_rdy,
  input  logic [31:0] imemresp_data,
  input  logic        imemresp_domain,
  output logic        inst_val,
  input  logic        inst_rdy,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fault
);

  localparam int CW = $clog2(p_max_inflight) + 1;
  localparam int PW = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(p_max_inflight - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(p_max_inflight);

  logic [31:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   tag_pc  [p_max_inflight];
  logic          tag_dom [p_max_inflight];
  logic [31:0]   head_pc;
  logic          head_dom;
  logic          mismatch;
  logic          req_fire;
  logic          resp_fire;

  // Circular pointer advance that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Oldest outstanding request's tag, paired with the response at the port.
  always_comb begin
    head_pc  = tag_pc[head];
    head_dom = tag_dom[head];
  end

`ifdef PLAB3_PROC_FETCH_DOMAIN_CHECK_EN
  assign mismatch = !reset && imemresp_val && (drop_cnt == '0) &&
                    (imemresp_domain != head_dom);
`else
  logic unused_dom;
  assign unused_dom = imemresp_domain ^ head_dom;
  assign mismatch   = 1'b0;
`endif

  assign imemreq_val    = !reset && !redirect_val && (inflight < MAX_CNT);
  assign imemreq_addr   = pc;
  assign imemreq_domain = sec_domain;
  assign req_fire       = imemreq_val && imemreq_rdy;

  // Stale (dropped) and mismatched responses are always sunk; live ones wait
  // for decode.
  assign imemresp_rdy = ((drop_cnt != '0) || redirect_val || mismatch) ? 1'b1 : inst_rdy;
  assign resp_fire    = imemresp_val && imemresp_rdy;

  assign inst_val = !reset && imemresp_val && (drop_cnt == '0) && !redirect_val && !mismatch;
  assign inst     = imemresp_data;
  assign inst_pc  = head_pc;
  assign fault    = mismatch;

  // Fetch PC: reset vector, redirect target, or sequential advance.
  always_ff @(posedge clk) begin
    if (reset)             pc <= c_reset_vector;
    else if (redirect_val) pc <= redirect_pc;
    else if (req_fire)     pc <= pc + 32'd4;
  end

  // Occupancy, squash count and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
      drop_cnt <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      // Everything still outstanding at a redirect is stale; a response
      // leaving this cycle is already accounted for.
      if (redirect_val)
        drop_cnt <= inflight - CW'(resp_fire);
      else if (resp_fire && (drop_cnt != '0))
        drop_cnt <= drop_cnt - 1'b1;
      if (req_fire)  tail <= next_ptr(tail);
      if (resp_fire) head <= next_ptr(head);
    end
  end

  // Tag storage: written on request fire, never reset.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_pc[tail]  <= pc;
      tag_dom[tail] <= sec_domain;
    end
  end

endmodule

// File: tb/tb_plab3_proc_fetch_unit.sv
// Bench for plab3_proc_fetch_unit: directed vector table, hand-written
// corner sequences, then randomized traffic against a queue-based model.
module tb_plab3_proc_fetch_unit;

  localparam int          P  = 2;
  localparam logic [31:0] RV = 32'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sec_domain = 1'b0;
  logic        redirect_val = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imemreq_val;
  logic        imemreq_rdy = 1'b0;
  logic [31:0] imemreq_addr;
  logic        imemreq_domain;
  logic        imemresp_val = 1'b0;
  logic        imemresp_rdy;
  logic [31:0] imemresp_data = '0;
  logic        imemresp_domain = 1'b0;
  logic        inst_val;
  logic        inst_rdy = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fault;

  always #5 clk = ~clk;

  plab3_proc_fetch_unit #(.p_max_inflight(P), .c_reset_vector(RV)) dut (
    .clk(clk), .reset(reset), .sec_domain(sec_domain),
    .redirect_val(redirect_val), .redirect_pc(redirect_pc),
    .imemreq_val(imemreq_val), .imemreq_rdy(imemreq_rdy),
    .imemreq_addr(imemreq_addr), .imemreq_domain(imemreq_domain),
    .imemresp_val(imemresp_val), .imemresp_rdy(imemresp_rdy),
    .imemresp_data(imemresp_data), .imemresp_domain(imemresp_domain),
    .inst_val(inst_val), .inst_rdy(inst_rdy), .inst(inst), .inst_pc(inst_pc),
    .fault(fault)
  );

  typedef struct {
    logic        rst, redir;
    logic [31:0] rpc;
    logic        q_rdy, r_val;
    logic [31:0] r_data;
    logic        r_dom, i_rdy, sec;
    logic        q_val;
    logic [31:0] q_addr;
    logic        r_rdy, i_val;
    logic [31:0] i_pc;
    logic        flt;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        dom;
  } tag_t;

  tag_t        mq[$];
  logic [31:0] m_pc = RV;
  int          m_drop = 0;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[25];

  function automatic vec_t mk(int rst, int redir, logic [31:0] rpc, int qrdy, int rval,
                              logic [31:0] rdata, int rdom, int irdy, int sec,
                              int qval, logic [31:0] qaddr, int rrdy, int ival,
                              logic [31:0] ipc, int flt);
    vec_t v;
    v.rst = (rst != 0);   v.redir = (redir != 0); v.rpc = rpc;
    v.q_rdy = (qrdy != 0); v.r_val = (rval != 0); v.r_data = rdata;
    v.r_dom = (rdom != 0); v.i_rdy = (irdy != 0); v.sec = (sec != 0);
    v.q_val = (qval != 0); v.q_addr = qaddr; v.r_rdy = (rrdy != 0);
    v.i_val = (ival != 0); v.i_pc = ipc; v.flt = (flt != 0);
    return v;
  endfunction

  // Reference model: outputs from the outstanding-request queue and rules.
  function automatic void model_eval(input vec_t vin, output vec_t vout);
    tag_t h;
    logic mism;
    vout = vin;
    h.pc = '0; h.dom = 1'b0;
    if (mq.size() > 0) h = mq[0];
    mism = 1'b0;
`ifdef PLAB3_PROC_FETCH_DOMAIN_CHECK_EN
    mism = !vin.rst && vin.r_val && (m_drop == 0) && (vin.r_dom != h.dom);
`endif
    vout.q_val  = !vin.rst && !vin.redir && (mq.size() < P);
    vout.q_addr = m_pc;
    vout.r_rdy  = (m_drop != 0 || vin.redir || mism) ? 1'b1 : vin.i_rdy;
    vout.i_val  = !vin.rst && vin.r_val && (m_drop == 0) && !vin.redir && !mism;
    vout.i_pc   = h.pc;
    vout.flt    = mism;
  endfunction

  function automatic void model_update(input vec_t v, input vec_t e);
    logic rfire, qfire;
    tag_t t;
    if (v.rst) begin
      mq.delete(); m_pc = RV; m_drop = 0;
    end else begin
      rfire = v.r_val && e.r_rdy;
      qfire = e.q_val && v.q_rdy;
      if (v.redir) m_drop = mq.size() - (rfire ? 1 : 0);
      else if (rfire && m_drop > 0) m_drop--;
      if (rfire && mq.size() > 0) void'(mq.pop_front());
      if (qfire) begin t.pc = m_pc; t.dom = v.sec; mq.push_back(t); end
      if (v.redir) m_pc = v.rpc;
      else if (qfire) m_pc = m_pc + 32'd4;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, compare outputs, then clock.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    reset = v.rst; redirect_val = v.redir; redirect_pc = v.rpc;
    imemreq_rdy = v.q_rdy; imemresp_val = v.r_val; imemresp_data = v.r_data;
    imemresp_domain = v.r_dom; inst_rdy = v.i_rdy; sec_domain = v.sec;
    #2;
    model_eval(v, e);
    chk({tag, ".req_val"}, 32'(imemreq_val), 32'(v.q_val));
    chk({tag, ".req_dom"}, 32'(imemreq_domain), 32'(v.sec));
    if (!v.rst) begin
      chk({tag, ".req_addr"}, imemreq_addr, v.q_addr);
      chk({tag, ".resp_rdy"}, 32'(imemresp_rdy), 32'(v.r_rdy));
    end
    chk({tag, ".inst_val"}, 32'(inst_val), 32'(v.i_val));
    if (v.i_val) begin
      chk({tag, ".inst_pc"}, inst_pc, v.i_pc);
      chk({tag, ".inst"}, inst, v.r_data);
    end
    chk({tag, ".fault"}, 32'(fault), 32'(v.flt));
    @(posedge clk);
    model_update(v, e);
  endtask

  initial begin
    vec_t v, e;
    logic [31:0] tmp;
    logic sec_cur;

    // rst redir rpc  qrdy rval rdata rdom irdy sec | qval qaddr rrdy ival ipc fault
    tbl[0]  = mk(1,0,0, 0,0,0,0,1,0, 0,RV,1,0,0,0);
    tbl[1]  = mk(1,0,0, 0,0,0,0,1,0, 0,RV,1,0,0,0);
    tbl[2]  = mk(0,0,0, 1,0,0,0,1,0, 1,32'h1000,1,0,0,0);
    tbl[3]  = mk(0,0,0, 1,1,32'hA0,0,1,0, 1,32'h1004,1,1,32'h1000,0);
    tbl[4]  = mk(0,0,0, 1,1,32'hA1,0,1,0, 1,32'h1008,1,1,32'h1004,0);
    tbl[5]  = mk(0,0,0, 0,1,32'hA2,0,1,0, 1,32'h100c,1,1,32'h1008,0);
    tbl[6]  = mk(1,0,0, 0,0,0,0,1,0, 0,RV,1,0,0,0);
    tbl[7]  = mk(0,0,0, 1,0,0,0,1,0, 1,32'h1000,1,0,0,0);
    tbl[8]  = mk(0,0,0, 1,0,0,0,1,0, 1,32'h1004,1,0,0,0);
    tbl[9]  = mk(0,0,0, 1,0,0,0,1,0, 0,32'h1008,1,0,0,0);
    tbl[10] = mk(0,0,0, 1,0,0,0,1,0, 0,32'h1008,1,0,0,0);
    tbl[11] = mk(0,0,0, 1,1,32'hB0,0,1,0, 0,32'h1008,1,1,32'h1000,0);
    tbl[12] = mk(0,0,0, 1,0,0,0,1,0, 1,32'h1008,1,0,0,0);
    tbl[13] = mk(0,1,32'h2000, 1,0,0,0,1,0, 0,32'h100c,1,0,0,0);
    tbl[14] = mk(0,0,0, 1,1,32'hC0,0,0,0, 0,32'h2000,1,0,0,0);
    tbl[15] = mk(0,0,0, 1,1,32'hC1,0,0,0, 1,32'h2000,1,0,0,0);
    tbl[16] = mk(0,0,0, 1,1,32'hC2,0,1,0, 1,32'h2004,1,1,32'h2000,0);
    tbl[17] = mk(0,0,0, 1,0,0,0,1,0, 1,32'h2008,1,0,0,0);
    tbl[18] = mk(0,1,32'h3000, 1,1,32'hD0,0,0,0, 0,32'h200c,1,0,0,0);
    tbl[19] = mk(0,0,0, 0,1,32'hD1,0,1,0, 1,32'h3000,1,0,0,0);
    tbl[20] = mk(0,0,0, 1,0,0,0,1,0, 1,32'h3000,1,0,0,0);
    tbl[21] = mk(0,0,0, 0,1,32'hD2,0,1,0, 1,32'h3004,1,1,32'h3000,0);
    tbl[22] = mk(0,0,0, 1,0,0,0,1,0, 1,32'h3004,1,0,0,0);
    tbl[23] = mk(0,0,0, 0,1,32'hD3,0,0,0, 1,32'h3008,0,1,32'h3004,0);
    tbl[24] = mk(0,0,0, 0,1,32'hD3,0,1,0, 1,32'h3008,1,1,32'h3004,0);

    for (int i = 0; i < 25; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Domain mismatch on a response.
    apply(mk(1,0,0, 0,0,0,0,1,1, 0,RV,1,0,0,0), "dom.rst");
    apply(mk(0,0,0, 1,0,0,0,1,1, 1,32'h1000,1,0,0,0), "dom.req");
`ifdef PLAB3_PROC_FETCH_DOMAIN_CHECK_EN
    apply(mk(0,0,0, 0,1,32'hE0,0,1,1, 1,32'h1004,1,0,0,1), "dom.resp");
`else
    apply(mk(0,0,0, 0,1,32'hE0,0,1,1, 1,32'h1004,1,1,32'h1000,0), "dom.resp");
`endif
    #1;
    chk("dom.inflight", 32'(dut.inflight), 32'd0);
    apply(mk(0,0,0, 0,0,0,0,1,1, 1,32'h1004,1,0,0,0), "dom.after");

    // Reset with two requests in flight and a pending squash.
    apply(mk(1,0,0, 0,0,0,0,1,0, 0,RV,1,0,0,0), "mrst.rst0");
    apply(mk(0,0,0, 1,0,0,0,1,0, 1,32'h1000,1,0,0,0), "mrst.req0");
    apply(mk(0,0,0, 1,0,0,0,1,0, 1,32'h1004,1,0,0,0), "mrst.req1");
    apply(mk(0,1,32'h4000, 1,0,0,0,1,0, 0,32'h1008,1,0,0,0), "mrst.redir");
    apply(mk(1,0,0, 1,0,0,0,1,0, 0,RV,1,0,0,0), "mrst.rst1");
    #1;
    chk("mrst.inflight", 32'(dut.inflight), 32'd0);
    chk("mrst.drop_cnt", 32'(dut.drop_cnt), 32'd0);
    apply(mk(0,0,0, 1,0,0,0,1,0, 1,32'h1000,1,0,0,0), "mrst.req2");
    apply(mk(0,0,0, 0,1,32'hF0,0,1,0, 1,32'h1004,1,1,32'h1000,0), "mrst.resp");

    // Randomized traffic against the model.
    sec_cur = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      v = mk(0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0);
      v.rst   = (n < 2) || ($urandom_range(199) == 0);
      v.redir = !v.rst && ($urandom_range(9) == 0);
      tmp     = $urandom();
      v.rpc   = {tmp[31:2], 2'b00};
      v.q_rdy = ($urandom_range(9) < 7);
      v.r_val = !v.rst && (mq.size() > 0) && ($urandom_range(9) < 6);
      v.r_data = $urandom();
      v.r_dom = ((mq.size() > 0) ? mq[0].dom : 1'b0) ^ ($urandom_range(7) == 0);
      v.i_rdy = ($urandom_range(9) < 7);
      if ($urandom_range(4) == 0) sec_cur = ~sec_cur;
      v.sec = sec_cur;
      model_eval(v, e);
      apply(e, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
